// File: rtl/inst_loader.sv
// inst_loader: byte-stream boot loader (byte_data/valid/ready in) writing imem_we/addr/wdata, holding the core via cpu_hold until load_done, flagging load_error
module inst_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR} state_t;
  state_t state, nxt;
  logic [15:0] count;
  logic [1:0] idx;
  logic [7:0] csum;
  logic [23:0] word;
  logic acc;
  assign acc = byte_valid && byte_ready;
  always_comb begin
    nxt = state;
    if (acc)
      case (state)
        CNT_LO: nxt = CNT_HI;
        CNT_HI: nxt = 32'({byte_data, count[7:0]}) > MAX_WORDS ? ERROR :
                      {byte_data, count[7:0]} == 16'd0 ? CHECK : DATA;
        DATA: nxt = idx == 2'd3 && words_loaded + 16'd1 == count ? CHECK : DATA;
        CHECK: nxt = byte_data == csum ? DONE : ERROR;
        default: nxt = state;
      endcase
  end
  always_ff @(posedge clk) state <= reset ? CNT_LO : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      idx <= '0;
      csum <= '0;
      word <= '0;
      imem_we <= 1'b0;
      imem_addr <= ADDR_BASE;
      imem_wdata <= '0;
      words_loaded <= '0;
      byte_ready <= 1'b1;
      cpu_hold <= 1'b1;
      load_done <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= acc && state == DATA && idx == 2'd3;
      byte_ready <= nxt != DONE && nxt != ERROR;
      cpu_hold <= nxt != DONE;
      load_done <= nxt == DONE;
      load_error <= nxt == ERROR;
      if (imem_we) begin
        imem_addr <= imem_addr + 32'd4;
        words_loaded <= words_loaded + 16'd1;
      end
      if (acc) begin
        csum <= csum ^ byte_data;
        if (state == CNT_LO) count[7:0] <= byte_data;
        if (state == CNT_HI) count[15:8] <= byte_data;
        if (state == DATA) begin
          idx <= idx + 2'd1;
          word <= {byte_data, word[23:8]};
          if (idx == 2'd3) imem_wdata <= {byte_data, word};
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scoreboard bench driving two loaders (base 0 and base 0xFFFF_FFFC) with the same stream
module tb_inst_loader;
  logic clk = 1'b0, reset = 1'b1, byte_valid = 1'b0;
  logic [7:0] byte_data = '0, x;
  logic ready0, we0, hold0, done0, err0, ready1, we1, hold1, done1, err1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [15:0] words0, words1;
  logic [63:0] q0[$], q1[$], e0, e1;
  logic [31:0] img[4];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  inst_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(256)) u0 (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready0),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .cpu_hold(hold0),
    .load_done(done0), .load_error(err0), .words_loaded(words0)
  );
  inst_loader #(.ADDR_BASE(32'hFFFF_FFFC), .MAX_WORDS(256)) u1 (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .cpu_hold(hold1),
    .load_done(done1), .load_error(err1), .words_loaded(words1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (we0) begin
      if (q0.size() == 0) check("we0_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("addr0", addr0, e0[63:32]);
        check("wdata0", wdata0, e0[31:0]);
      end
    end
  always @(negedge clk)
    if (we1) begin
      if (q1.size() == 0) check("we1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("addr1", addr1, e1[63:32]);
        check("wdata1", wdata1, e1[31:0]);
      end
    end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'hA5;
    @(posedge clk);
    #1 reset = 1'b0;
    byte_valid = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("rst_ready0", ready0, 1); check("rst_ready1", ready1, 1);
    check("rst_we0", we0, 0); check("rst_we1", we1, 0);
    check("rst_addr0", addr0, 32'h0); check("rst_addr1", addr1, 32'hFFFF_FFFC);
    check("rst_wdata0", wdata0, 0); check("rst_wdata1", wdata1, 0);
    check("rst_hold0", hold0, 1); check("rst_hold1", hold1, 1);
    check("rst_done0", done0, 0); check("rst_done1", done1, 0);
    check("rst_err0", err0, 0); check("rst_err1", err1, 0);
    check("rst_words0", words0, 0); check("rst_words1", words1, 0);
  endtask
  task automatic send(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    byte_data = b;
    byte_valid = 1'b1;
    while (!ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
    x ^= b;
  endtask
  task automatic send_word(input int k, input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        q0.push_back({32'(4 * k), w});
        q1.push_back({32'hFFFF_FFFC + 32'(4 * k), w});
      end
      send(w[8*i +: 8], gaps);
    end
  endtask
  task automatic frame(input logic [15:0] n, input int nw, input logic [7:0] flip, input bit gaps);
    x = '0;
    send(n[7:0], gaps);
    send(n[15:8], gaps);
    for (int k = 0; k < nw; k++) send_word(k, img[k], gaps);
    send(x ^ flip, gaps);
  endtask
  task automatic end_check(input logic d, input logic e, input logic [15:0] w);
    @(negedge clk);
    check("done0", done0, d); check("done1", done1, d);
    check("err0", err0, e); check("err1", err1, e);
    check("hold0", hold0, !d); check("hold1", hold1, !d);
    check("ready0", ready0, 0); check("ready1", ready1, 0);
    check("words0", words0, w); check("words1", words1, w);
    check("pending0", q0.size(), 0); check("pending1", q1.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    img[0] = 32'h8B02_0020; img[1] = 32'hD65F_03C0;
    frame(16'd2, 2, 8'h00, 1'b0);
    end_check(1'b1, 1'b0, 16'd2);
    do_reset();
    frame(16'd0, 0, 8'h00, 1'b0);
    end_check(1'b1, 1'b0, 16'd0);
    do_reset();
    img[0] = 32'h9100_0421;
    frame(16'd1, 1, 8'h01, 1'b0);
    end_check(1'b0, 1'b1, 16'd1);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("err_sticky", err0, 1); check("err_ready", ready0, 0);
    check("err_done", done0, 0); check("err_words", words0, 1);
    do_reset();
    x = '0;
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    end_check(1'b0, 1'b1, 16'd0);
    do_reset();
    img[0] = 32'hF800_0020; img[1] = 32'h17FF_FFFF;
    frame(16'd2, 2, 8'h00, 1'b1);
    end_check(1'b1, 1'b0, 16'd2);
    do_reset();
    img[0] = 32'hAA00_0001; img[1] = 32'h1234_5678;
    x = '0;
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    send_word(0, img[0], 1'b0);
    send(img[1][7:0], 1'b0);
    send(img[1][15:8], 1'b0);
    @(negedge clk);
    check("abort_pending", q0.size(), 0);
    check("abort_words", words0, 1);
    do_reset();
    img[0] = 32'hB400_0040;
    frame(16'd1, 1, 8'h00, 1'b0);
    end_check(1'b1, 1'b0, 16'd1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
